// File: rtl/dmux_stream.sv
// Registered 1-to-N valid/ready stream demultiplexer: each beat lands in one per-channel output slot.
// Define DMUX_STREAM_BROADCAST_EN to add the in_bcast input (load every channel at once).
module dmux_stream #(
    parameter int W     = 8,
    parameter int N     = 4,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W-1:0]           in_data,
    input  logic [$clog2(N)-1:0]   in_sel,
`ifdef DMUX_STREAM_BROADCAST_EN
    input  logic                   in_bcast,
`endif
    output logic [N-1:0]           out_valid,
    input  logic [N-1:0]           out_ready,
    output logic [N*W-1:0]         out_data,
    output logic                   err_sel,
    output logic [CNT_W-1:0]       drop_cnt
);

    localparam int SEL_W = $clog2(N);
    // One extra bit so the out-of-range test also works when N is a power of two.
    localparam logic [SEL_W:0] N_EXT = (SEL_W + 1)'(N);

    logic [N-1:0]     free;
    logic [N-1:0]     sel_hit;
    logic [N-1:0]     load;
    logic             sel_bad;
    logic             sel_free;
    logic             bcast;
    logic             acc;
    logic             drop;
    logic             err_sel_reg;
    logic [CNT_W-1:0] drop_cnt_reg;

    always_comb begin
        sel_bad  = ({1'b0, in_sel} >= N_EXT);
        sel_free = |(sel_hit & free);
        bcast    = 1'b0;
`ifdef DMUX_STREAM_BROADCAST_EN
        bcast    = in_valid && in_bcast;
`endif
        if (bcast) begin
            in_ready = &free;
        end else if (sel_bad) begin
            in_ready = 1'b1;
        end else begin
            in_ready = sel_free;
        end
        acc  = in_valid && in_ready;
        drop = acc && sel_bad && !bcast;
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_ch
            localparam logic [SEL_W-1:0] IDX = SEL_W'(gi);

            logic         valid_reg;
            logic [W-1:0] data_reg;

            assign sel_hit[gi] = (in_sel == IDX);
            assign free[gi]    = !valid_reg || out_ready[gi];
            assign load[gi]    = acc && (bcast || sel_hit[gi]);

            // A load wins over a drain, so a slot can be emptied and refilled in the same cycle.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_reg <= 1'b0;
                    data_reg  <= '0;
                end else if (load[gi]) begin
                    valid_reg <= 1'b1;
                    data_reg  <= in_data;
                end else if (valid_reg && out_ready[gi]) begin
                    valid_reg <= 1'b0;
                end
            end

            assign out_valid[gi]          = valid_reg;
            assign out_data[gi*W +: W]    = data_reg;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sel_reg  <= 1'b0;
            drop_cnt_reg <= '0;
        end else begin
            err_sel_reg <= drop;
            if (drop && (drop_cnt_reg != {CNT_W{1'b1}})) begin
                drop_cnt_reg <= drop_cnt_reg + 1'b1;
            end
        end
    end

    assign err_sel  = err_sel_reg;
    assign drop_cnt = drop_cnt_reg;

endmodule

// File: tb/tb_dmux_stream.sv
// Self-checking bench for dmux_stream: table vectors, directed corner sequences and a randomized run
// against a slot-level reference model (N=4 instance) plus an N=3 instance for invalid selects.
module tb_dmux_stream;

    logic clk;
    logic rst;

    // N=4, W=8, CNT_W=8 instance
    logic        iv4;
    logic        rdy4;
    logic [7:0]  d4;
    logic [1:0]  sel4;
    logic [3:0]  ov4;
    logic [3:0]  or4;
    logic [31:0] od4;
    logic        err4;
    logic [7:0]  cnt4;
`ifdef DMUX_STREAM_BROADCAST_EN
    logic        bc4;
    logic        bc3;
`endif

    // N=3, W=8, CNT_W=2 instance
    logic        iv3;
    logic        rdy3;
    logic [7:0]  d3;
    logic [1:0]  sel3;
    logic [2:0]  ov3;
    logic [2:0]  or3;
    logic [23:0] od3;
    logic        err3;
    logic [1:0]  cnt3;

    int tests = 0;
    int fails = 0;

    dmux_stream #(.W(8), .N(4), .CNT_W(8)) u_dut4 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (iv4),
        .in_ready (rdy4),
        .in_data  (d4),
        .in_sel   (sel4),
`ifdef DMUX_STREAM_BROADCAST_EN
        .in_bcast (bc4),
`endif
        .out_valid(ov4),
        .out_ready(or4),
        .out_data (od4),
        .err_sel  (err4),
        .drop_cnt (cnt4)
    );

    dmux_stream #(.W(8), .N(3), .CNT_W(2)) u_dut3 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (iv3),
        .in_ready (rdy3),
        .in_data  (d3),
        .in_sel   (sel3),
`ifdef DMUX_STREAM_BROADCAST_EN
        .in_bcast (bc3),
`endif
        .out_valid(ov3),
        .out_ready(or3),
        .out_data (od3),
        .err_sel  (err3),
        .drop_cnt (cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [1:0] sel;
        logic [7:0] data;
        logic [3:0] ordy;
        logic       exp_rdy;
        logic [3:0] exp_ov;
        int         chk_ch;
        logic [7:0] exp_d;
    } vec_t;

    vec_t vecs[9];

    function automatic vec_t mk(input logic iv, input logic [1:0] sel, input logic [7:0] data,
                                input logic [3:0] ordy, input logic exp_rdy, input logic [3:0] exp_ov,
                                input int chk_ch, input logic [7:0] exp_d);
        vec_t v;
        v.iv = iv; v.sel = sel; v.data = data; v.ordy = ordy;
        v.exp_rdy = exp_rdy; v.exp_ov = exp_ov; v.chk_ch = chk_ch; v.exp_d = exp_d;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model state: one slot per channel
    logic       m_full[4];
    logic [7:0] m_data[4];

    initial begin
        logic       pend;
        logic [1:0] psel;
        logic [7:0] pdata;
        logic       exp_r;
        int         accepted;
        int         delivered;

        vecs[0] = mk(1'b1, 2'd2, 8'hA5, 4'b0000, 1'b1, 4'b0100, 2, 8'hA5);
        vecs[1] = mk(1'b1, 2'd2, 8'h5A, 4'b0000, 1'b0, 4'b0100, 2, 8'hA5);
        vecs[2] = mk(1'b1, 2'd1, 8'h11, 4'b0000, 1'b1, 4'b0110, 2, 8'hA5);
        vecs[3] = mk(1'b1, 2'd2, 8'h5A, 4'b0100, 1'b1, 4'b0110, 2, 8'h5A);
        vecs[4] = mk(1'b1, 2'd1, 8'h22, 4'b0010, 1'b1, 4'b0110, 1, 8'h22);
        vecs[5] = mk(1'b0, 2'd2, 8'h00, 4'b0110, 1'b1, 4'b0000, 2, 8'h5A);
        vecs[6] = mk(1'b1, 2'd0, 8'h77, 4'b0000, 1'b1, 4'b0001, 0, 8'h77);
        vecs[7] = mk(1'b0, 2'd0, 8'h00, 4'b0000, 1'b0, 4'b0001, 0, 8'h77);
        vecs[8] = mk(1'b0, 2'd3, 8'h00, 4'b0001, 1'b1, 4'b0000, 0, 8'h77);

        rst = 1'b1;
        iv4 = 1'b0; d4 = '0; sel4 = '0; or4 = '0;
        iv3 = 1'b0; d3 = '0; sel3 = '0; or3 = '0;
`ifdef DMUX_STREAM_BROADCAST_EN
        bc4 = 1'b0; bc3 = 1'b0;
`endif

        // Reset state
        repeat (2) tick();
        check("rst_ov4", ov4, 4'b0000);
        check("rst_od4", od4, 32'h0);
        check("rst_err4", err4, 1'b0);
        check("rst_cnt4", cnt4, 8'h0);
        check("rst_ov3", ov3, 3'b000);
        check("rst_cnt3", cnt3, 2'b00);
        check("rst_err3", err3, 1'b0);
        #2 rst = 1'b0;
        tick();

        // Throughput: all consumers ready, one beat per cycle round-robin
        or4 = 4'b1111;
        for (int i = 0; i < 16; i++) begin
            iv4 = 1'b1; sel4 = 2'(i % 4); d4 = 8'(i);
            @(negedge clk);
            check("thru_ready", rdy4, 1'b1);
            tick();
            check("thru_valid", ov4, 4'b0001 << (i % 4));
            check("thru_data", od4[(i % 4)*8 +: 8], 8'(i));
            $display("[TB] thru beat %0d sel=%0d data=%02h", i, i % 4, od4[(i % 4)*8 +: 8]);
        end
        iv4 = 1'b0;
        tick();
        check("thru_empty", ov4, 4'b0000);

        // Randomized run against the slot model
        for (int k = 0; k < 4; k++) begin
            m_full[k] = 1'b0;
            m_data[k] = '0;
        end
        pend = 1'b0; psel = '0; pdata = '0;
        accepted = 0; delivered = 0;
        for (int c = 0; c < 500; c++) begin
            if (!pend) begin
                pend  = ($urandom_range(0, 3) != 0);
                psel  = 2'($urandom_range(0, 3));
                pdata = 8'($urandom);
            end
            iv4 = pend; sel4 = psel; d4 = pdata; or4 = 4'($urandom);
            @(negedge clk);
            exp_r = !m_full[psel] || or4[psel];
            check("rand_ready", rdy4, exp_r);
            for (int k = 0; k < 4; k++) begin
                check("rand_valid", ov4[k], m_full[k]);
                if (m_full[k]) check("rand_data", od4[k*8 +: 8], m_data[k]);
            end
            for (int k = 0; k < 4; k++) begin
                if (m_full[k] && or4[k]) begin
                    m_full[k] = 1'b0;
                    delivered++;
                end
            end
            if (pend && exp_r) begin
                m_full[psel] = 1'b1;
                m_data[psel] = pdata;
                accepted++;
                pend = 1'b0;
                $display("[TB] rand beat %0d sel=%0d data=%02h", accepted, psel, pdata);
            end
            tick();
        end
        iv4 = 1'b0; or4 = 4'b1111;
        @(negedge clk);
        for (int k = 0; k < 4; k++) if (m_full[k]) delivered++;
        check("rand_lost", 64'(delivered), 64'(accepted));
        check("rand_err4", err4, 1'b0);
        check("rand_cnt4", cnt4, 8'h0);
        tick();
        check("rand_drained", ov4, 4'b0000);

        // Invalid select on N=3, CNT_W=2
        check("inv_err_idle", err3, 1'b0);
        for (int i = 0; i < 5; i++) begin
            iv3 = 1'b1; sel3 = 2'd3; d3 = 8'h50 + 8'(i); or3 = 3'b000;
            @(negedge clk);
            check("inv_ready", rdy3, 1'b1);
            tick();
            check("inv_err", err3, 1'b1);
            check("inv_cnt", cnt3, (i < 3) ? 2'(i + 1) : 2'd3);
            check("inv_ov", ov3, 3'b000);
            $display("[TB] drop beat %0d err_sel=%0d drop_cnt=%0d", i, err3, cnt3);
        end
        iv3 = 1'b1; sel3 = 2'd0; d3 = 8'h66;
        @(negedge clk);
        check("inv_valid_ready", rdy3, 1'b1);
        tick();
        check("inv_err_clear", err3, 1'b0);
        check("inv_cnt_hold", cnt3, 2'd3);
        check("inv_ov_ch0", ov3, 3'b001);
        check("inv_od_ch0", od3[7:0], 8'h66);
        iv3 = 1'b0;
        tick();
        check("inv_err_quiet", err3, 1'b0);

        // Reset mid-run with channels 1 and 2 full
        or4 = 4'b0000;
        iv4 = 1'b1; sel4 = 2'd1; d4 = 8'h33;
        tick();
        sel4 = 2'd2; d4 = 8'h44;
        tick();
        check("mid_pre_ov", ov4, 4'b0110);
        #2 rst = 1'b1;
        #1;
        check("mid_ov", ov4, 4'b0000);
        check("mid_od", od4, 32'h0);
        check("mid_ready", rdy4, 1'b1);
        check("mid_cnt3", cnt3, 2'd0);
        check("mid_ov3", ov3, 3'b000);
        iv4 = 1'b0;
        @(posedge clk);
        #3 rst = 1'b0;
        tick();

        // Table vectors: route, stall, head-of-line blocking, refill, hold-on-drain
        for (int i = 0; i < 9; i++) begin
            iv4 = vecs[i].iv; sel4 = vecs[i].sel; d4 = vecs[i].data; or4 = vecs[i].ordy;
            @(negedge clk);
            check("vec_ready", rdy4, vecs[i].exp_rdy);
            tick();
            check("vec_valid", ov4, vecs[i].exp_ov);
            check("vec_data", od4[vecs[i].chk_ch*8 +: 8], vecs[i].exp_d);
            check("vec_err", err4, 1'b0);
            $display("[TB] vec %0d out_valid=%b ch%0d=%02h", i, ov4, vecs[i].chk_ch,
                     od4[vecs[i].chk_ch*8 +: 8]);
        end

`ifdef DMUX_STREAM_BROADCAST_EN
        // Broadcast waits for every slot to be free
        iv4 = 1'b1; sel4 = 2'd1; d4 = 8'h12; or4 = 4'b0000;
        tick();
        check("bc_pre_ov", ov4, 4'b0010);
        bc4 = 1'b1; sel4 = 2'd2; d4 = 8'h3C;
        @(negedge clk);
        check("bc_blocked", rdy4, 1'b0);
        tick();
        check("bc_hold_ov", ov4, 4'b0010);
        or4 = 4'b0010;
        @(negedge clk);
        check("bc_ready", rdy4, 1'b1);
        tick();
        check("bc_ov", ov4, 4'b1111);
        check("bc_od", od4, 32'h3C3C3C3C);
        check("bc_cnt", cnt4, 8'h0);
        check("bc_err", err4, 1'b0);
        $display("[TB] bcast beat out_valid=%b out_data=%08h", ov4, od4);
        bc4 = 1'b0; iv4 = 1'b0; or4 = 4'b1111;
        tick();
        check("bc_drained", ov4, 4'b0000);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmux_stream.md
Name: dmux_stream

Overview:
- Registered 1-to-N demultiplexer for streaming data with valid/ready handshakes.
- Parametrised successor to the single-bit combinational dmux: each beat is routed by `in_sel` into one of N per-channel output registers.
- Each channel drains independently under its own `out_ready`.
- Sits between a single producer and N consumers; sustains 1 beat/cycle per channel.

Parameters:
- W, 8: data width per beat.
- N, 4: number of output channels (2..16; need not be a power of two).
- CNT_W, 8: width of the saturating dropped-beat counter.
- SEL_W, derived localparam = $clog2(N): width of `in_sel`. Not overridable.

Ports:
- clk  input  1  — system clock; all state updates on rising edge.
- rst  input  1  — asynchronous, active-high reset.
- in_valid  input  1  — producer has a beat.
- in_ready  output  1  — block accepts the beat this cycle.
- in_data  input  W  — beat payload.
- in_sel  input  SEL_W  — destination channel index.
- out_valid  output  N  — bit k: channel k holds a beat.
- out_ready  input  N  — bit k: consumer k takes the beat.
- out_data  output  N*W  — channel k payload at bits [k*W +: W].
- err_sel  output  1  — 1-cycle pulse: a beat with `in_sel >= N` was dropped.
- drop_cnt  output  CNT_W  — saturating count of dropped beats.

Behaviour:
- Reset (async assert, sync release): `out_valid` = 0, `out_data` = 0, `err_sel` = 0, `drop_cnt` = 0. Any beats held at reset are discarded.
- Slot free: `free[k] = !out_valid[k] || out_ready[k]`.
- Ready: `in_ready = (in_sel >= N) ? 1 : free[in_sel]`. This path is combinational from `in_sel`/`out_ready` to `in_ready`. There is no combinational path from `in_*` to `out_*`.
- Producer rule: once `in_valid` is high, `in_data`/`in_sel` stay stable until accepted. `in_valid` does not drop before acceptance.
- Accept: `acc = in_valid && in_ready`.
- Latency: a beat accepted in cycle t appears on `out_valid[k]`/`out_data[k]` in cycle t+1.
- Channel k, per cycle, in priority order:
  - `acc && in_sel == k`: `out_data[k] <= in_data`, `out_valid[k] <= 1`. This also covers a simultaneous drain and refill, which gives back-to-back throughput.
  - else if `out_valid[k] && out_ready[k]`: `out_valid[k] <= 0`; `out_data[k]` holds its last value.
  - else: hold.
- Stall: while `out_valid[k] && !out_ready[k]`, `out_data[k]` is stable. A beat for k blocks the input (head-of-line blocking by design). Other channels keep draining.
- Invalid select (`acc && in_sel >= N`, possible only when N is not a power of two):
  - Beat is consumed and discarded; no channel changes.
  - `err_sel` = 1 for the next cycle only.
  - `drop_cnt` increments, saturating at 2^CNT_W-1.
- `err_sel` is registered and is 0 in every cycle not following a drop.
- Reset mid-transfer: all channels empty immediately; `in_ready` then follows the free-slot rule (all free).

Optional Feature:
- Macro: DMUX_STREAM_BROADCAST_EN.
- With the macro:
  - Extra input port `in_bcast` (1 bit).
  - When `in_valid && in_bcast`: `in_ready = &free` (all N slots free); `in_sel` is ignored.
  - On accept, every channel loads `in_data` and sets `out_valid`.
  - Broadcast beats never count as drops.
- Without the macro: `in_bcast` does not exist; behaviour is exactly as above.

Test Plan:
- Reset/route, N=4, W=8: assert rst mid-run with `out_valid`=4'b0110 -> `out_valid`=0 and `out_data`=0 immediately. Release, drive in_valid=1, in_sel=2, in_data=0xA5, out_ready=4'b0000 -> next cycle `out_valid`=4'b0100 and `out_data[2]`=0xA5.
- Stall/blocking: channel 2 full, out_ready[2]=0, next beat sel=2 -> `in_ready`=0 and `out_data[2]` holds 0xA5. A beat with sel=1 is accepted meanwhile. Raise out_ready[2] -> the sel=2 beat is accepted the same cycle (refill, `out_valid[2]` stays 1).
- Throughput: out_ready=4'b1111, 16 beats sel=0..3 cycling, data 0..15 -> `in_ready` always 1. Each channel outputs its beats in order, 1 cycle after acceptance, none lost.
- Invalid select, N=3, CNT_W=2: 5 beats with sel=3 -> each accepted; `err_sel` pulses 5 times; `drop_cnt` reads 1, 2, 3, 3, 3; `out_valid` stays 0.
- Broadcast (macro on), N=4: in_bcast=1, data 0x3C, channel 1 full and stalled -> `in_ready`=0. Free channel 1 -> accepted; next cycle `out_valid`=4'b1111 with all `out_data`=0x3C; `drop_cnt` unchanged.
